// File: rtl/cpu_sequencer_if.sv
// Bundle of decoder inputs, memory handshake and datapath strobes for cpu_sequencer.
// Latency: none (wires only); the optional retired_count appears with CPU_SEQUENCER_PERF_CNT_EN.
// Backpressure: memory stalls are expressed by mem_ack staying low while mem_req is high.
interface cpu_sequencer_if;
    // Decoder side
    logic [10:0] alu_ctl_code;
    logic        execute_flag;
    logic        cpsr_enable;
    // Shared memory port
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    // Datapath strobes and selects
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        decode_enable;
    logic        alu_enable;
    logic        reg_write;
    logic        mem_to_reg;
    logic        cpsr_write;
    logic        link_write;
    logic        illegal_op;
    logic [2:0]  state;
`ifdef CPU_SEQUENCER_PERF_CNT_EN
    logic [31:0] retired_count;

    // Sequencer view: consumes decoder fields and mem_ack, drives every strobe
    modport master (
        input  alu_ctl_code, execute_flag, cpsr_enable, mem_ack,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               decode_enable, alu_enable, reg_write, mem_to_reg,
               cpsr_write, link_write, illegal_op, state, retired_count
    );

    // Decoder/memory/datapath view
    modport slave (
        output alu_ctl_code, execute_flag, cpsr_enable, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               decode_enable, alu_enable, reg_write, mem_to_reg,
               cpsr_write, link_write, illegal_op, state, retired_count
    );
`else
    // Sequencer view: consumes decoder fields and mem_ack, drives every strobe
    modport master (
        input  alu_ctl_code, execute_flag, cpsr_enable, mem_ack,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               decode_enable, alu_enable, reg_write, mem_to_reg,
               cpsr_write, link_write, illegal_op, state
    );

    // Decoder/memory/datapath view
    modport slave (
        output alu_ctl_code, execute_flag, cpsr_enable, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               decode_enable, alu_enable, reg_write, mem_to_reg,
               cpsr_write, link_write, illegal_op, state
    );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle Moore control sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/BRANCH) for a simple CPU.
// Latency FETCH->FETCH with zero-wait memory: ALU/B/BL/STR 4, LDR 5, cond-fail/illegal 3 cycles.
// Backpressure: FETCH and MEMORY hold mem_req until mem_ack; optional CPU_SEQUENCER_PERF_CNT_EN adds retired_count.
module cpu_sequencer (
    input  logic             clk,
    input  logic             reset,
    cpu_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_BRANCH    = 3'd5
    } state_t;

    localparam logic [10:0] C_B   = 11'd31;
    localparam logic [10:0] C_BL  = 11'd32;
    localparam logic [10:0] C_LDR = 11'd41;
    localparam logic [10:0] C_STR = 11'd42;

    // Data-processing codes 0..13
    function automatic logic f_is_dp(input logic [10:0] code);
        return (code <= 11'd13);
    endfunction

    function automatic logic f_is_branch(input logic [10:0] code);
        return (code == C_B) || (code == C_BL);
    endfunction

    function automatic logic f_is_mem(input logic [10:0] code);
        return (code == C_LDR) || (code == C_STR);
    endfunction

    // Compare/test style ops: update flags only, never the register file
    function automatic logic f_is_flag_only(input logic [10:0] code);
        return (code == 11'd8) || (code == 11'd9) || (code == 11'd10) || (code == 11'd13);
    endfunction

    function automatic logic f_is_legal(input logic [10:0] code);
        return f_is_dp(code) || f_is_branch(code) || f_is_mem(code);
    endfunction

    state_t      r_state;
    // Instruction fields captured when DECODE completes
    logic [10:0] r_code;
    logic        r_exec;
    logic        r_s;
    // Registered strobes, computed for the state being entered
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_addr_sel;
    logic        r_pc_write_br;
    logic        r_pc_src;
    logic        r_decode_enable;
    logic        r_alu_enable;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_cpsr_write;
    logic        r_link_write;
    logic        r_illegal_op;

    // The instruction word lands this cycle. Qualified by r_mem_req so the
    // idle FETCH cycle right after reset cannot accept a stray mem_ack.
    logic w_fetch_done;
    assign w_fetch_done = (r_state == S_FETCH) && r_mem_req && bus.mem_ack;

    // Memory phase of LDR/STR completes this cycle
    logic w_mem_done;
    assign w_mem_done = (r_state == S_MEMORY) && bus.mem_ack;

    // Sequencer: next state plus the strobes that belong to that state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_FETCH;
            r_code          <= '0;
            r_exec          <= 1'b0;
            r_s             <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_addr_sel      <= 1'b0;
            r_pc_write_br   <= 1'b0;
            r_pc_src        <= 1'b0;
            r_decode_enable <= 1'b0;
            r_alu_enable    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_cpsr_write    <= 1'b0;
            r_link_write    <= 1'b0;
            r_illegal_op    <= 1'b0;
        end else begin
            // Every strobe is a single-state pulse unless re-asserted below
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_addr_sel      <= 1'b0;
            r_pc_write_br   <= 1'b0;
            r_pc_src        <= 1'b0;
            r_decode_enable <= 1'b0;
            r_alu_enable    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_cpsr_write    <= 1'b0;
            r_link_write    <= 1'b0;
            r_illegal_op    <= 1'b0;

            case (r_state)
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_state         <= S_DECODE;
                        r_decode_enable <= 1'b1;
                    end else begin
                        // Keep (or, after reset, start) the instruction request
                        r_mem_req       <= 1'b1;
                    end
                end

                S_DECODE: begin
                    // Decoder outputs are sampled exactly once, here
                    r_code  <= bus.alu_ctl_code;
                    r_exec  <= bus.execute_flag;
                    r_s     <= bus.cpsr_enable;
                    r_state <= S_EXECUTE;
                    if (bus.execute_flag) begin
                        if (f_is_dp(bus.alu_ctl_code) || f_is_mem(bus.alu_ctl_code)) begin
                            // ALU op, or address generation for LDR/STR
                            r_alu_enable <= 1'b1;
                        end else if (!f_is_branch(bus.alu_ctl_code)) begin
                            r_illegal_op <= 1'b1;
                        end
                    end
                end

                S_EXECUTE: begin
                    if (!r_exec || !f_is_legal(r_code)) begin
                        // Condition failed or undefined opcode: drop it
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end else if (f_is_dp(r_code)) begin
                        r_state      <= S_WRITEBACK;
                        r_reg_write  <= !f_is_flag_only(r_code);
                        r_cpsr_write <= r_s || f_is_flag_only(r_code);
                    end else if (f_is_branch(r_code)) begin
                        r_state       <= S_BRANCH;
                        r_pc_write_br <= 1'b1;
                        r_pc_src      <= 1'b1;
                        r_link_write  <= (r_code == C_BL);
                    end else begin
                        r_state    <= S_MEMORY;
                        r_mem_req  <= 1'b1;
                        r_addr_sel <= 1'b1;
                        r_mem_we   <= (r_code == C_STR);
                    end
                end

                S_MEMORY: begin
                    if (w_mem_done) begin
                        if (r_code == C_STR) begin
                            r_state   <= S_FETCH;
                            r_mem_req <= 1'b1;
                        end else begin
                            // LDR result goes back to the register file
                            r_state      <= S_WRITEBACK;
                            r_reg_write  <= 1'b1;
                            r_mem_to_reg <= 1'b1;
                            r_cpsr_write <= r_s;
                        end
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_addr_sel <= 1'b1;
                        r_mem_we   <= (r_code == C_STR);
                    end
                end

                S_WRITEBACK, S_BRANCH: begin
                    r_state   <= S_FETCH;
                    r_mem_req <= 1'b1;
                end

                default: begin
                    r_state   <= S_FETCH;
                    r_mem_req <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state         = r_state;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_we        = r_mem_we;
    assign bus.addr_sel      = r_addr_sel;
    // Instruction register and PC+4 update ride on the fetch acknowledge
    assign bus.ir_write      = w_fetch_done;
    assign bus.pc_write      = w_fetch_done || r_pc_write_br;
    assign bus.pc_src        = r_pc_src;
    assign bus.decode_enable = r_decode_enable;
    assign bus.alu_enable    = r_alu_enable;
    assign bus.reg_write     = r_reg_write;
    assign bus.mem_to_reg    = r_mem_to_reg;
    assign bus.cpsr_write    = r_cpsr_write;
    assign bus.link_write    = r_link_write;
    assign bus.illegal_op    = r_illegal_op;

`ifdef CPU_SEQUENCER_PERF_CNT_EN
    // An instruction retires when it re-enters FETCH having done real work
    logic        w_retire;
    logic [31:0] r_retired_count;
    assign w_retire = (r_state == S_WRITEBACK) || (r_state == S_BRANCH)
                   || (w_mem_done && (r_code == C_STR));

    // Free-running retire counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_count <= '0;
        end else if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign bus.retired_count = r_retired_count;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Random + directed bench for cpu_sequencer: a trace model predicts every cycle's outputs.
// Latency: expected vectors are pushed as inputs are driven and popped by the monitor the same cycle.
// Backpressure: random fetch/memory wait states are inserted by the bench acting as memory.
module tb_cpu_sequencer;

    logic clk;
    logic reset;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
        logic decode_enable, alu_enable, reg_write, mem_to_reg;
        logic cpsr_write, link_write, illegal_op;
    } out_t;

    typedef struct {
        logic ack;
        logic dec;
        logic retire;
        out_t exp;
    } cyc_t;

    typedef struct {
        out_t        exp;
        logic [31:0] cnt;
    } chk_t;

    chk_t        exp_q[$];
    cyc_t        plan[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 0;
    logic [10:0] ill_codes [7] = '{11'd14, 11'd20, 11'd30, 11'd33, 11'd40, 11'd43, 11'd2047};

    function automatic out_t cur_out();
        out_t o;
        o.state         = bus.state;
        o.mem_req       = bus.mem_req;
        o.mem_we        = bus.mem_we;
        o.addr_sel      = bus.addr_sel;
        o.ir_write      = bus.ir_write;
        o.pc_write      = bus.pc_write;
        o.pc_src        = bus.pc_src;
        o.decode_enable = bus.decode_enable;
        o.alu_enable    = bus.alu_enable;
        o.reg_write     = bus.reg_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.cpsr_write    = bus.cpsr_write;
        o.link_write    = bus.link_write;
        o.illegal_op    = bus.illegal_op;
        return o;
    endfunction

    task automatic add(input out_t o, input logic ack, input logic dec, input logic retire);
        cyc_t c;
        c.ack = ack; c.dec = dec; c.retire = retire; c.exp = o;
        plan.push_back(c);
    endtask

    // Cycle-by-cycle trace of one instruction, straight from the behavioural rules
    task automatic build_plan(input logic [10:0] code, input logic ef, input logic s,
                              input int fw, input int mw);
        out_t o;
        logic dp, br, mem, flag, illegal;
        dp      = (code <= 11'd13);
        br      = (code == 11'd31) || (code == 11'd32);
        mem     = (code == 11'd41) || (code == 11'd42);
        flag    = (code == 11'd8) || (code == 11'd9) || (code == 11'd10) || (code == 11'd13);
        illegal = !(dp || br || mem);
        plan.delete();
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1'b1;
            add(o, 1'b0, 1'b0, 1'b0);
        end
        o = '0; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        add(o, 1'b1, 1'b0, 1'b0);
        o = '0; o.state = 3'd1; o.decode_enable = 1'b1;
        add(o, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        o = '0; o.state = 3'd2;
        if (ef) begin
            if (dp || mem) o.alu_enable = 1'b1;
            else if (illegal) o.illegal_op = 1'b1;
        end
        add(o, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (!ef || illegal) return;
        if (dp) begin
            o = '0; o.state = 3'd4; o.reg_write = !flag; o.cpsr_write = s || flag;
            add(o, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end else if (br) begin
            o = '0; o.state = 3'd5; o.pc_write = 1'b1; o.pc_src = 1'b1;
            o.link_write = (code == 11'd32);
            add(o, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end else begin
            o = '0; o.state = 3'd3; o.mem_req = 1'b1; o.addr_sel = 1'b1;
            o.mem_we = (code == 11'd42);
            for (int i = 0; i < mw; i++) add(o, 1'b0, 1'b0, 1'b0);
            add(o, 1'b1, 1'b0, (code == 11'd42));
            if (code == 11'd41) begin
                o = '0; o.state = 3'd4; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.cpsr_write = s;
                add(o, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            end
        end
    endtask

    task automatic push_exp(input out_t o);
        chk_t c;
        c.exp = o; c.cnt = model_cnt;
        exp_q.push_back(c);
    endtask

    // Drive the planned cycles; stop_at >= 0 asserts reset in that cycle and ends early
    task automatic run_plan(input logic [10:0] code, input logic ef, input logic s,
                            input int stop_at, input bit wrap);
        for (int k = 0; k < plan.size(); k++) begin
            @(posedge clk); #1;
`ifdef CPU_SEQUENCER_PERF_CNT_EN
            if (wrap && k == 0) begin
                force dut.r_retired_count = 32'hFFFF_FFFF;
                model_cnt = 32'hFFFF_FFFF;
            end
            if (wrap && k == 1) release dut.r_retired_count;
`endif
            bus.mem_ack = plan[k].ack;
            if (plan[k].dec) begin
                bus.alu_ctl_code = code; bus.execute_flag = ef; bus.cpsr_enable = s;
            end else begin
                bus.alu_ctl_code = 11'($urandom_range(0, 2047));
                bus.execute_flag = 1'($urandom_range(0, 1));
                bus.cpsr_enable  = 1'($urandom_range(0, 1));
            end
            push_exp(plan[k].exp);
            if (plan[k].retire) model_cnt = model_cnt + 32'd1;
            if (k == stop_at) begin
                reset = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_instr(input logic [10:0] code, input logic ef, input logic s,
                            input int fw, input int mw);
        build_plan(code, ef, s, fw, mw);
        run_plan(code, ef, s, -1, 1'b0);
    endtask

    // Monitor: every cycle with a pending expectation is compared
    initial begin
        chk_t e;
        out_t got;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = cur_out();
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got state=%0d vec=%b exp state=%0d vec=%b",
                             cyc, got.state, got[12:0], e.exp.state, e.exp[12:0]);
                end
`ifdef CPU_SEQUENCER_PERF_CNT_EN
                checks++;
                if (bus.retired_count !== e.cnt) begin
                    errors++;
                    $display("FAIL retired_count cyc=%0d got=%h exp=%h", cyc, bus.retired_count, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [10:0] code;
        logic        ef, s;
        int          sel;
        reset = 1'b1;
        bus.alu_ctl_code = '0; bus.execute_flag = 1'b0; bus.cpsr_enable = 1'b0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        // Held in reset: idle FETCH, every strobe low
        repeat (2) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b1;
            push_exp('0);
        end
        // Reset released: still idle this cycle, a stray ack must not fetch
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp('0);

        // Directed: ADD S twice, CMP, LDR with 3 waits, BL, B, cond-fail STR, illegal, STR
        do_instr(11'd0,  1'b1, 1'b1, 0, 0);
        do_instr(11'd0,  1'b1, 1'b1, 0, 0);
        do_instr(11'd8,  1'b1, 1'b0, 0, 0);
        do_instr(11'd41, 1'b1, 1'b0, 0, 3);
        do_instr(11'd32, 1'b1, 1'b0, 0, 0);
        do_instr(11'd31, 1'b1, 1'b0, 0, 0);
        do_instr(11'd42, 1'b0, 1'b0, 0, 0);
        do_instr(11'd20, 1'b1, 1'b0, 0, 0);
        do_instr(11'd42, 1'b1, 1'b1, 2, 1);
        do_instr(11'd13, 1'b1, 1'b0, 1, 0);

`ifdef CPU_SEQUENCER_PERF_CNT_EN
        // Counter at all-ones, one B retire must wrap it to zero
        build_plan(11'd31, 1'b1, 1'b0, 0, 0);
        run_plan(11'd31, 1'b1, 1'b0, -1, 1'b1);
`endif

        // Reset in the middle of a stalled LDR memory access
        build_plan(11'd41, 1'b1, 1'b0, 0, 6);
        run_plan(11'd41, 1'b1, 1'b0, 4, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        model_cnt = '0;
        push_exp('0);

        // Randomized instruction stream with random wait states
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: code = 11'($urandom_range(0, 13));
                4:          code = 11'd31;
                5:          code = 11'd32;
                6:          code = 11'd41;
                7:          code = 11'd42;
                8:          code = ill_codes[$urandom_range(0, 6)];
                default:    code = 11'($urandom_range(0, 2047));
            endcase
            ef = ($urandom_range(0, 4) != 0);
            s  = 1'($urandom_range(0, 1));
            do_instr(code, ef, s,
                     ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                     ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
        end

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
